// File: rtl/regfile_pkg.sv
// Shared register-file constants and the register index type; the register
// file imports the same package so index widths cannot drift apart.
package regfile_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NREG      = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: scans upward from ptr (mod N) and grants the
// first valid requester, returning both a onehot grant and its index.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx
);

    logic found;
    int   j;

    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && valid[j]) begin
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port, with
// a pending-write scoreboard for decode stalls. Define REGFILE_WB_BYPASS_EN to
// add the write-port bypass (fwd_* outputs) and drop the extra stall cycle.
module regfile_wb_arbiter #(
    parameter int N_REQ = 2,
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREG  = regfile_pkg::NREG
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_REQ-1:0]                    req_valid,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic [N_REQ*regfile_pkg::REG_IDX_W-1:0] req_rd,
    input  logic [N_REQ*XLEN-1:0]               req_data,
    input  logic                                alloc_valid,
    input  logic [regfile_pkg::REG_IDX_W-1:0]   alloc_rd,
    input  logic [regfile_pkg::REG_IDX_W-1:0]   rs1,
    input  logic [regfile_pkg::REG_IDX_W-1:0]   rs2,
    output logic                                busy_rs1,
    output logic                                busy_rs2,
    output logic                                RegWrite,
    output logic [regfile_pkg::REG_IDX_W-1:0]   rd,
    output logic [XLEN-1:0]                     WriteData,
    output logic                                alloc_err
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic                                fwd_rs1_en,
    output logic                                fwd_rs2_en,
    output logic [XLEN-1:0]                     fwd_rs1_data,
    output logic [XLEN-1:0]                     fwd_rs2_data
`endif
);

    import regfile_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] rr_ptr;
    logic             hs;
    reg_idx_t         sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pending_nxt;
    logic             alloc_set;
    logic             alloc_conflict;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);
    assign sel_rd    = req_rd[grant_idx*REG_IDX_W +: REG_IDX_W];
    assign sel_data  = req_data[grant_idx*XLEN +: XLEN];

    // A write clearing the same index on this edge means the old producer is
    // finishing, so re-allocating it is legal rather than a protocol error.
    assign alloc_set      = alloc_valid && (alloc_rd != '0);
    assign alloc_conflict = alloc_set && pending[alloc_rd] && !(RegWrite && (rd == alloc_rd));

    // NOTE: combinational next-state uses blocking '=' so later lines see the
    // earlier updates; the set is applied after the clear so a newer producer wins.
    always_comb begin
        pending_nxt = pending;
        if (RegWrite) pending_nxt[rd] = 1'b0;
        if (alloc_set) pending_nxt[alloc_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // NOTE: the scoreboard bit array is reset like any other state, so a reset
    // mid-operation forgets every outstanding write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            RegWrite  <= 1'b0;
            rd        <= '0;
            WriteData <= '0;
            pending   <= '0;
            alloc_err <= 1'b0;
        end else begin
            RegWrite  <= hs && (sel_rd != '0);
            if (hs) begin
                rd        <= sel_rd;
                WriteData <= sel_data;
                rr_ptr    <= (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + 1'b1;
            end
            pending   <= pending_nxt;
            alloc_err <= alloc_err | alloc_conflict;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign fwd_rs1_en   = RegWrite && (rd == rs1) && (rs1 != '0);
    assign fwd_rs2_en   = RegWrite && (rd == rs2) && (rs2 != '0);
    assign fwd_rs1_data = WriteData;
    assign fwd_rs2_data = WriteData;
    assign busy_rs1     = pending[rs1] && !fwd_rs1_en;
    assign busy_rs2     = pending[rs2] && !fwd_rs2_en;
`else
    assign busy_rs1 = pending[rs1];
    assign busy_rs2 = pending[rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: writes are checked by a scoreboard
// monitor, arbitration/scoreboard outputs by inline checks.
module tb_regfile_wb_arbiter;

    localparam int N_REQ = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ-1:0]  req_ready;
    logic [N_REQ*5-1:0]  req_rd;
    logic [N_REQ*32-1:0] req_data;
    logic              alloc_valid;
    logic [4:0]        alloc_rd;
    logic [4:0]        rs1, rs2;
    logic              busy_rs1, busy_rs2;
    logic              RegWrite;
    logic [4:0]        rd;
    logic [31:0]       WriteData;
    logic              alloc_err;
`ifdef REGFILE_WB_BYPASS_EN
    logic              fwd_rs1_en, fwd_rs2_en;
    logic [31:0]       fwd_rs1_data, fwd_rs2_data;
`endif

    wr_t exp_q[$];
    int  pass_cnt  = 0;
    int  total_cnt = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(N_REQ), .XLEN(32), .NREG(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .busy_rs1    (busy_rs1),
        .busy_rs2    (busy_rs2),
        .RegWrite    (RegWrite),
        .rd          (rd),
        .WriteData   (WriteData),
        .alloc_err   (alloc_err)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .fwd_rs1_en   (fwd_rs1_en),
        .fwd_rs2_en   (fwd_rs2_en),
        .fwd_rs1_data (fwd_rs1_data),
        .fwd_rs2_data (fwd_rs2_data)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic drive_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
        req_valid[i]        = v;
        req_rd[i*5 +: 5]    = r;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
        wr_t w;
        w.rd   = r;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every performed register-file write must match the oldest expectation.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && RegWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {59'd0, rd}, 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_rd", {59'd0, rd}, {59'd0, w.rd});
                    check("wr_data", {32'd0, WriteData}, {32'd0, w.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        rs1         = 5'd7;
        rs2         = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        check("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        check("rst_rd", {59'd0, rd}, 64'd0);
        check("rst_wdata", {32'd0, WriteData}, 64'd0);
        check("rst_alloc_err", {63'd0, alloc_err}, 64'd0);
        check("rst_ready", {62'd0, req_ready}, 64'd0);
        check("rst_busy1", {63'd0, busy_rs1}, 64'd0);
        rst_n = 1'b1;
        cyc();

        // Single request on requester 0.
        drive_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #3 check("single_ready", {62'd0, req_ready}, 64'h1);
        expect_write(5'd5, 32'hDEAD_BEEF);
        cyc();
        drive_req(0, 1'b0, 5'd0, 32'd0);
        #3 check("idle_ready", {62'd0, req_ready}, 64'd0);
        cyc();
        check("single_regwrite_drop", {63'd0, RegWrite}, 64'd0);

        // Requester 1 alone: grant and pointer back to 0.
        drive_req(1, 1'b1, 5'd3, 32'h0000_0033);
        #3 check("req1_ready", {62'd0, req_ready}, 64'h2);
        expect_write(5'd3, 32'h0000_0033);
        cyc();
        drive_req(1, 1'b0, 5'd0, 32'd0);

        // Both requesters held valid: grants alternate 0,1,0,1.
        drive_req(0, 1'b1, 5'd1, 32'hAAAA_0001);
        drive_req(1, 1'b1, 5'd2, 32'hBBBB_0002);
        for (int k = 0; k < 4; k++) begin
            #3;
            if (k % 2 == 0) begin
                check("rr_ready0", {62'd0, req_ready}, 64'h1);
                expect_write(5'd1, 32'hAAAA_0001);
            end else begin
                check("rr_ready1", {62'd0, req_ready}, 64'h2);
                expect_write(5'd2, 32'hBBBB_0002);
            end
            cyc();
        end
        req_valid = '0;

        // Allocation of x7 stalls rs1 until its write has landed.
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        cyc();
        alloc_valid = 1'b0;
        rs1         = 5'd7;
        #3 check("busy7_after_alloc", {63'd0, busy_rs1}, 64'h1);
        cyc();
        drive_req(0, 1'b1, 5'd7, 32'hC0DE_0007);
        #3 check("busy7_hs_cycle", {63'd0, busy_rs1}, 64'h1);
        expect_write(5'd7, 32'hC0DE_0007);
        cyc();
        drive_req(0, 1'b0, 5'd0, 32'd0);
        #3;
`ifdef REGFILE_WB_BYPASS_EN
        check("busy7_bypass", {63'd0, busy_rs1}, 64'd0);
        check("fwd7_en", {63'd0, fwd_rs1_en}, 64'h1);
        check("fwd7_data", {32'd0, fwd_rs1_data}, {32'd0, 32'hC0DE_0007});
`else
        check("busy7_write_cycle", {63'd0, busy_rs1}, 64'h1);
`endif
        cyc();
        #3 check("busy7_cleared", {63'd0, busy_rs1}, 64'd0);
        cyc();

        // Same-edge clear and re-allocate of x9, then a genuine double allocation.
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        cyc();
        alloc_valid = 1'b0;
        drive_req(0, 1'b1, 5'd9, 32'h0000_0999);
        expect_write(5'd9, 32'h0000_0999);
        cyc();
        drive_req(0, 1'b0, 5'd0, 32'd0);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        cyc();
        alloc_valid = 1'b0;
        rs2         = 5'd9;
        #3;
        check("same_edge_busy9", {63'd0, busy_rs2}, 64'h1);
        check("same_edge_no_err", {63'd0, alloc_err}, 64'd0);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        cyc();
        alloc_valid = 1'b0;
        #3;
        check("double_alloc_err", {63'd0, alloc_err}, 64'h1);
        check("double_alloc_busy9", {63'd0, busy_rs2}, 64'h1);
        cyc();

        // Writeback to x0 is consumed without a register-file write.
        drive_req(0, 1'b1, 5'd0, 32'hFFFF_0000);
        #3 check("rd0_ready", {62'd0, req_ready}, 64'h1);
        cyc();
        drive_req(0, 1'b0, 5'd0, 32'd0);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd0;
        rs1         = 5'd0;
        #3 check("rd0_no_write", {63'd0, RegWrite}, 64'd0);
        cyc();
        alloc_valid = 1'b0;
        #3 check("x0_never_busy", {63'd0, busy_rs1}, 64'd0);
        cyc();

        // Reset while a write is registered but not yet performed.
        alloc_valid = 1'b1;
        alloc_rd    = 5'd12;
        cyc();
        alloc_valid = 1'b0;
        rs1         = 5'd12;
        #3 check("busy12_set", {63'd0, busy_rs1}, 64'h1);
        drive_req(0, 1'b1, 5'd4, 32'h0000_D00D);
        cyc();
        drive_req(0, 1'b0, 5'd0, 32'd0);
        #1 check("pre_reset_regwrite", {63'd0, RegWrite}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_regwrite", {63'd0, RegWrite}, 64'd0);
        check("async_rst_busy12", {63'd0, busy_rs1}, 64'd0);
        check("async_rst_err", {63'd0, alloc_err}, 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_rst_no_write", {63'd0, RegWrite}, 64'd0);
        drive_req(0, 1'b1, 5'd1, 32'h1111_0001);
        drive_req(1, 1'b1, 5'd2, 32'h2222_0002);
        #3 check("post_rst_ptr0", {62'd0, req_ready}, 64'h1);
        expect_write(5'd1, 32'h1111_0001);
        cyc();
        req_valid = '0;
        repeat (3) cyc();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
